// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-cycle fetch with a skid register for stalls and branch redirect.
// Optional macro FETCH_BUBBLE_NOP_EN: bubbles are emitted as a valid NOP instead of instr_valid=0.
module fetch_stage #(
    parameter int unsigned      ARQ      = 32,
    parameter logic [ARQ-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [25:0]     branch_target,
    output logic            imem_req,
    output logic [ARQ-1:0]  imem_addr,
    input  logic            imem_ready,
    input  logic [ARQ-1:0]  imem_rdata,
    output logic [ARQ-1:0]  instr_out,
    output logic [ARQ-1:0]  pc_out,
    output logic            instr_valid
);

    localparam logic [ARQ-1:0] NOP = ARQ'(32'h7000_0000);
`ifdef FETCH_BUBBLE_NOP_EN
    localparam logic BUBBLE_VALID = 1'b1;
`else
    localparam logic BUBBLE_VALID = 1'b0;
`endif

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HOLD} state_t;

    state_t         state, state_n;
    logic [ARQ-1:0] pc, pc_n;
    logic [ARQ-1:0] instr_n, pc_out_n;
    logic           valid_n;
    logic [ARQ-1:0] skid_instr, skid_instr_n;
    logic [ARQ-1:0] skid_pc, skid_pc_n;

    assign imem_addr = pc;

    // Next-state, request and output-register update logic
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = instr_out;
        pc_out_n     = pc_out;
        valid_n      = instr_valid;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        imem_req     = 1'b0;

        if (!rst) begin
            if (branch_taken) begin
                state_n      = S_RUN;
                pc_n         = ARQ'(branch_target);
                skid_instr_n = '0;
                skid_pc_n    = '0;
                instr_n      = NOP;
                valid_n      = BUBBLE_VALID;
            end else begin
                case (state)
                    S_RUN: begin
                        if (!stall) begin
                            imem_req = 1'b1;
                            if (imem_ready) begin
                                instr_n  = imem_rdata;
                                pc_out_n = pc;
                                valid_n  = 1'b1;
                                pc_n     = pc + ARQ'(1);
                            end else begin
                                instr_n = NOP;
                                valid_n = BUBBLE_VALID;
                                state_n = S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        imem_req = 1'b1;
                        if (imem_ready) begin
                            pc_n = pc + ARQ'(1);
                            if (stall) begin
                                skid_instr_n = imem_rdata;
                                skid_pc_n    = pc;
                                state_n      = S_HOLD;
                            end else begin
                                instr_n  = imem_rdata;
                                pc_out_n = pc;
                                valid_n  = 1'b1;
                                state_n  = S_RUN;
                            end
                        end else if (!stall) begin
                            instr_n = NOP;
                            valid_n = BUBBLE_VALID;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            instr_n  = skid_instr;
                            pc_out_n = skid_pc;
                            valid_n  = 1'b1;
                            state_n  = S_RUN;
                        end
                    end
                    default: state_n = S_RUN;
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RUN;
            pc          <= RESET_PC;
            instr_out   <= NOP;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_out   <= instr_n;
            pc_out      <= pc_out_n;
            instr_valid <= valid_n;
            skid_instr  <= skid_instr_n;
            skid_pc     <= skid_pc_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected {instr, pc}; a negedge monitor pops on each new delivery.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h7000_0000;
`ifdef FETCH_BUBBLE_NOP_EN
    localparam logic BUBBLE_V = 1'b1;
`else
    localparam logic BUBBLE_V = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, imem_ready;
    logic [25:0] branch_target;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    fetch_stage #(.ARQ(32), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // Memory returns an address-tagged word that can never look like NOP
    assign imem_rdata = 32'hA000_0000 | imem_addr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_q.push_back({word(a), a});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a delivery is a valid non-NOP output that differs from the previous sample
    logic [64:0] prev = '0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (instr_valid && instr_out != NOP && {instr_valid, instr_out, pc_out} != prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_delivery: got instr=%h pc=%h expected none", instr_out, pc_out);
            end else begin
                e = exp_q.pop_front();
                if ({instr_out, pc_out} !== e) begin
                    bad++;
                    $display("FAIL delivery: got instr=%h pc=%h expected instr=%h pc=%h",
                             instr_out, pc_out, e[63:32], e[31:0]);
                end
            end
        end
        prev <= {instr_valid, instr_out, pc_out};
    end

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
        cyc();
        chk("req_in_reset", 32'(imem_req), 32'd0);
        cyc();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_pc_out", pc_out, 32'd0);

        // Streaming fetch, ready tied high
        rst = 1'b0;
        for (int i = 0; i < 5; i++) push(32'(i));
        cyc();
        chk("first_word_latency", instr_out, word(32'd0));
        repeat (4) cyc();

        // Memory not ready for three cycles at PC=5
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, 32'd5);
            cyc();
            chk("wait_bubble_valid", 32'(instr_valid), 32'(BUBBLE_V));
            chk("wait_bubble_instr", instr_out, NOP);
        end
        imem_ready = 1'b1;
        push(32'd5);
        cyc();

        // Stall rises in WAIT, response goes to skid register
        imem_ready = 1'b0;
        cyc();
        stall = 1'b1;
        #1;
        chk("stall_wait_req", 32'(imem_req), 32'd1);
        chk("stall_wait_addr", imem_addr, 32'd6);
        cyc();
        imem_ready = 1'b1;
        push(32'd6);
        cyc();
        #1;
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_instr_unchanged", instr_out, NOP);
        cyc();
        chk("hold_valid_unchanged", 32'(instr_valid), 32'(BUBBLE_V));
        stall = 1'b0; imem_ready = 1'b0;
        #1;
        chk("hold_release_req", 32'(imem_req), 32'd0);
        cyc();
        chk("skid_pc_out", pc_out, 32'd6);
        imem_ready = 1'b1;
        #1;
        chk("pc_continues", imem_addr, 32'd7);
        push(32'd7);
        cyc();

        // Branch overrides stall and a same-cycle response
        imem_ready = 1'b0;
        cyc();
        stall = 1'b1; imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 26'h0AC;
        #1;
        chk("branch_req", 32'(imem_req), 32'd0);
        cyc();
        chk("branch_bubble_instr", instr_out, NOP);
        chk("branch_bubble_valid", 32'(instr_valid), 32'(BUBBLE_V));
        branch_taken = 1'b0; stall = 1'b0;
        #1;
        chk("branch_target_addr", imem_addr, 32'h0AC);
        chk("branch_target_req", 32'(imem_req), 32'd1);
        push(32'h0AC);
        cyc();
        stall = 1'b1;
        #1;
        chk("run_stall_req", 32'(imem_req), 32'd0);
        cyc();
        chk("run_stall_pc_hold", pc_out, 32'h0AC);
        chk("run_stall_valid_hold", 32'(instr_valid), 32'd1);

        // Reset in the middle of WAIT
        stall = 1'b0; imem_ready = 1'b0;
        cyc();
        rst = 1'b1; imem_ready = 1'b1;
        #1;
        chk("rst_wait_req", 32'(imem_req), 32'd0);
        cyc();
        chk("rst_wait_pc_out", pc_out, 32'd0);
        chk("rst_wait_valid", 32'(instr_valid), 32'd0);
        chk("rst_wait_instr", instr_out, NOP);
        rst = 1'b0;
        #1;
        chk("after_rst_addr", imem_addr, 32'd0);
        chk("after_rst_req", 32'(imem_req), 32'd1);
        push(32'd0);
        cyc();
        imem_ready = 1'b0;
        repeat (2) cyc();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL take parameter ARQ, default 32, meaning the instruction and PC width in bits.
REQ-002 The block SHALL take parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port stall  input  1  decode cannot accept; hold instr_out/pc_out/instr_valid.
REQ-006 The block SHALL have port branch_taken  input  1  redirect request from the jump/branch logic.
REQ-007 The block SHALL have port branch_target  input  26  word address, the decoded addr field, zero-extended to ARQ.
REQ-008 The block SHALL have port imem_req  output  1  instruction memory read request.
REQ-009 The block SHALL have port imem_addr  output  ARQ  word address of the request, equal to PC.
REQ-010 The block SHALL have port imem_ready  input  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1.
REQ-011 The block SHALL have port imem_rdata  input  ARQ  instruction word.
REQ-012 The block SHALL have port instr_out  output  ARQ  registered instruction feeding the decoder.
REQ-013 The block SHALL have port pc_out  output  ARQ  word address of instr_out.
REQ-014 The block SHALL have port instr_valid  output  1  instr_out holds a real instruction.

Function
REQ-015 PC SHALL be word-addressed and advance by 1 per accepted response, wrapping modulo 2^ARQ.
REQ-016 FSM states SHALL be RUN (no outstanding request), WAIT (request outstanding), HOLD (response buffered in skid register).
REQ-017 RUN: if !stall, imem_req=1 with imem_addr=PC; if imem_ready, load instr_out/pc_out and set instr_valid=1, PC+1, stay RUN; else go WAIT; if stall, imem_req=0 and stay RUN.
REQ-018 WAIT: imem_req SHALL stay 1 with imem_addr stable regardless of stall until imem_ready.
REQ-019 WAIT with imem_ready and !stall: load output register, PC+1, go RUN; with imem_ready and stall: load skid register (word and PC), PC+1, go HOLD.
REQ-020 HOLD: imem_req=0; on the first cycle with !stall, move skid to the output register with instr_valid=1 and go RUN.
REQ-021 While stall=1, instr_out, pc_out and instr_valid SHALL hold; when stall=0 and no word is loaded that cycle, a bubble SHALL be written (see REQ-027).
REQ-022 Fetch latency SHALL be one cycle: a word accepted in cycle N appears on instr_out in cycle N+1.
REQ-023 branch_taken SHALL override stall and all states: PC loaded with branch_target, skid discarded, any same-cycle imem_ready response discarded, output written as bubble, state RUN, imem_req=0 that cycle.
REQ-024 Priority SHALL be rst > branch_taken > stall > normal fetch.

Reset
REQ-025 On rst: PC=RESET_PC, state RUN, instr_valid=0, instr_out=32'h7000_0000 (NOP), pc_out=RESET_PC, skid cleared.
REQ-026 While rst=1, imem_req SHALL be 0; a reset during WAIT abandons the request and its response SHALL be ignored.

Configuration
REQ-027 With FETCH_BUBBLE_NOP_EN defined, bubbles SHALL be instr_out=32'h7000_0000 (NOP), instr_valid=1; without it, bubbles SHALL be instr_valid=0 with instr_out holding NOP.

Verification
REQ-028 Reset, imem_ready tied 1, stall=0, memory returns addr-indexed words -> instr_out shows words 0,1,2 on consecutive cycles, pc_out 0,1,2.
REQ-029 imem_ready low 3 cycles at PC=5 -> imem_addr held 5, imem_req held 1, bubbles out, word 5 appears cycle after ready.
REQ-030 stall rises in WAIT, ready arrives -> state HOLD, imem_req=0, instr_out unchanged; stall drops -> buffered word out next cycle, PC continues.
REQ-031 branch_taken with branch_target=0xAC in the same cycle as imem_ready and stall=1 -> response dropped, bubble out, next request imem_addr=0xAC.
REQ-032 Both macro builds: after a redirect, check bubble encoding per REQ-027 (instr_valid 1 with NOP vs instr_valid 0).
REQ-033 rst asserted mid-WAIT -> imem_req=0 next cycle, PC=RESET_PC, late imem_ready ignored.
